// File: rtl/price_mon_pkg.sv
// Shared types for the price band monitor: zone encoding and the threshold classifier.
package price_mon_pkg;

  typedef enum logic [1:0] {
    ZONE_IDLE = 2'b00,
    ZONE_BAND = 2'b01,
    ZONE_LOW  = 2'b10,
    ZONE_HIGH = 2'b11
  } zone_t;

  localparam int CLASS_W = 32;

  // Strict hysteresis: prices equal to a threshold still fall in the band.
  function automatic zone_t classify(input logic [CLASS_W-1:0] price,
                                     input logic [CLASS_W-1:0] upper,
                                     input logic [CLASS_W-1:0] lower);
    zone_t z;
    z = ZONE_BAND;
    if (price > upper)      z = ZONE_HIGH;
    else if (price < lower) z = ZONE_LOW;
    return z;
  endfunction

endpackage

// File: rtl/price_band_channel.sv
// One price channel: classify each valid sample, debounce zone changes, hold the committed zone.
module price_band_channel
  import price_mon_pkg::*;
#(
  parameter int PRICE_W = 8,
  parameter int CNT_W   = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sample_en,
  input  logic               clr,
  input  logic [PRICE_W-1:0] price,
  input  logic [PRICE_W-1:0] upper,
  input  logic [PRICE_W-1:0] lower,
  input  logic [CNT_W-1:0]   debounce,
  output zone_t              zone,
  output logic               commit,
  output zone_t              commit_zone
);

  zone_t            zone_q, zone_d, cand_q, cand_d, cls;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, thr;

  always_comb begin
    cls     = classify(CLASS_W'(price), CLASS_W'(upper), CLASS_W'(lower));
    thr     = (debounce == '0) ? CNT_W'(1) : debounce;
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    zone_d  = zone_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    if (clr) begin
      cand_d = ZONE_IDLE;
      cnt_d  = '0;
    end else if (sample_en) begin
      if (cls == zone_q) begin
        cnt_d = '0;
      end else begin
        if (cls == cand_q) begin
          cnt_d = cnt_inc;
        end else begin
          cand_d = cls;
          cnt_d  = CNT_W'(1);
        end
        if (cnt_d >= thr) begin
          zone_d = cand_d;
          cnt_d  = '0;
          commit = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      zone_q <= ZONE_IDLE;
      cand_q <= ZONE_IDLE;
      cnt_q  <= '0;
    end else begin
      zone_q <= zone_d;
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end

  assign zone        = zone_q;
  assign commit_zone = zone_d;

endmodule

// File: rtl/price_band_monitor.sv
// Multi-channel price zone monitor: shared config registers, per-channel debounce,
// pending-event bits and a round-robin arbiter feeding a single valid/ready event register.
module price_band_monitor
  import price_mon_pkg::*;
#(
  parameter int NUM_CH           = 4,
  parameter int PRICE_W          = 8,
  parameter int CNT_W            = 4,
  parameter int DEFAULT_UPPER    = 105,
  parameter int DEFAULT_LOWER    = 95,
  parameter int DEFAULT_DEBOUNCE = 3,
  localparam int CH_W            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_CH-1:0]         price_valid,
  input  logic [NUM_CH*PRICE_W-1:0] price,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [PRICE_W-1:0]        cfg_upper,
  input  logic [PRICE_W-1:0]        cfg_lower,
  input  logic [CNT_W-1:0]          cfg_debounce,
  output logic                      cfg_err,
  output logic [NUM_CH*2-1:0]       zone,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [CH_W-1:0]           evt_ch,
  output logic [1:0]                evt_zone,
  output logic                      evt_overrun
);

  if (DEFAULT_UPPER < DEFAULT_LOWER) begin : g_bad_defaults
    $error("price_band_monitor: DEFAULT_UPPER must be >= DEFAULT_LOWER");
  end

  logic [PRICE_W-1:0] upper_q, upper_d, lower_q, lower_d;
  logic [CNT_W-1:0]   deb_q, deb_d;
  logic               apply_q, apply_d, apply_ok_q, apply_ok_d, cfg_err_q, cfg_err_d;
  logic               accept, cfg_ok;
  logic [NUM_CH-1:0]  pend_q, pend_d, commit, grant_hit;
  zone_t              pzone_q [NUM_CH];
  zone_t              pzone_d [NUM_CH];
  zone_t              ch_zone [NUM_CH];
  zone_t              cm_zone [NUM_CH];
  logic               evt_valid_q, evt_valid_d, ovr_q, ovr_d, found;
  logic [CH_W-1:0]    evt_ch_q, evt_ch_d, last_q, last_d, idx, gidx;
  logic [1:0]         evt_zone_q, evt_zone_d;

  // Channels see no samples during the apply cycle; a valid config clears their debounce then.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    price_band_channel #(.PRICE_W(PRICE_W), .CNT_W(CNT_W)) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .sample_en  (price_valid[c] & ~apply_q),
      .clr        (apply_ok_q),
      .price      (price[c*PRICE_W +: PRICE_W]),
      .upper      (upper_q),
      .lower      (lower_q),
      .debounce   (deb_q),
      .zone       (ch_zone[c]),
      .commit     (commit[c]),
      .commit_zone(cm_zone[c])
    );
    assign zone[c*2 +: 2] = ch_zone[c];
  end

  always_comb begin
    accept     = cfg_valid & ~apply_q;
    cfg_ok     = cfg_upper >= cfg_lower;
    upper_d    = upper_q;
    lower_d    = lower_q;
    deb_d      = deb_q;
    apply_d    = accept;
    apply_ok_d = accept & cfg_ok;
    cfg_err_d  = accept & ~cfg_ok;
    if (accept && cfg_ok) begin
      upper_d = cfg_upper;
      lower_d = cfg_lower;
      deb_d   = cfg_debounce;
    end

    pend_d      = pend_q;
    pzone_d     = pzone_q;
    evt_valid_d = evt_valid_q;
    evt_ch_d    = evt_ch_q;
    evt_zone_d  = evt_zone_q;
    last_d      = last_q;
    grant_hit   = '0;
    found       = 1'b0;
    idx         = '0;
    gidx        = '0;
    ovr_d       = 1'b0;

    if (!evt_valid_q || evt_ready) begin
      for (int i = 1; i <= NUM_CH; i++) begin
        idx = CH_W'((int'(last_q) + i) % NUM_CH);
        if (!found && pend_q[idx]) begin
          found = 1'b1;
          gidx  = idx;
        end
      end
      if (found) begin
        evt_valid_d     = 1'b1;
        evt_ch_d        = gidx;
        evt_zone_d      = pzone_q[gidx];
        pend_d[gidx]    = 1'b0;
        last_d          = gidx;
        grant_hit[gidx] = 1'b1;
      end else begin
        evt_valid_d = 1'b0;
      end
    end

    // A commit landing on a channel granted this cycle refills its pending slot, not an overrun.
    for (int c = 0; c < NUM_CH; c++) begin
      if (commit[c]) begin
        if (pend_q[c] && !grant_hit[c]) ovr_d = 1'b1;
        pend_d[c]  = 1'b1;
        pzone_d[c] = cm_zone[c];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      upper_q     <= PRICE_W'(DEFAULT_UPPER);
      lower_q     <= PRICE_W'(DEFAULT_LOWER);
      deb_q       <= CNT_W'(DEFAULT_DEBOUNCE);
      apply_q     <= 1'b0;
      apply_ok_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
      pend_q      <= '0;
      pzone_q     <= '{default: ZONE_IDLE};
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      evt_zone_q  <= '0;
      last_q      <= CH_W'(NUM_CH - 1);
      ovr_q       <= 1'b0;
    end else begin
      upper_q     <= upper_d;
      lower_q     <= lower_d;
      deb_q       <= deb_d;
      apply_q     <= apply_d;
      apply_ok_q  <= apply_ok_d;
      cfg_err_q   <= cfg_err_d;
      pend_q      <= pend_d;
      pzone_q     <= pzone_d;
      evt_valid_q <= evt_valid_d;
      evt_ch_q    <= evt_ch_d;
      evt_zone_q  <= evt_zone_d;
      last_q      <= last_d;
      ovr_q       <= ovr_d;
    end
  end

  assign cfg_ready   = ~apply_q;
  assign cfg_err     = cfg_err_q;
  assign evt_valid   = evt_valid_q;
  assign evt_ch      = evt_ch_q;
  assign evt_zone    = evt_zone_q;
  assign evt_overrun = ovr_q;

endmodule

// File: tb/tb_price_band_monitor.sv
// Bench for price_band_monitor: directed vector table, reset corner sequences, random run vs model.
module tb_price_band_monitor;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  price_valid;
  logic [31:0] price;
  logic        cfg_valid, cfg_ready, cfg_err;
  logic [7:0]  cfg_upper, cfg_lower;
  logic [3:0]  cfg_debounce;
  logic [7:0]  zone;
  logic        evt_valid, evt_ready, evt_overrun;
  logic [1:0]  evt_ch, evt_zone;

  always #5 clk = ~clk;

  price_band_monitor #(
    .NUM_CH(4), .PRICE_W(8), .CNT_W(4),
    .DEFAULT_UPPER(105), .DEFAULT_LOWER(95), .DEFAULT_DEBOUNCE(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .price_valid(price_valid), .price(price),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_upper(cfg_upper),
    .cfg_lower(cfg_lower), .cfg_debounce(cfg_debounce), .cfg_err(cfg_err),
    .zone(zone), .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ch(evt_ch),
    .evt_zone(evt_zone), .evt_overrun(evt_overrun)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: zones as integers 0 idle, 1 band, 2 low, 3 high.
  int m_zone[4], m_cand[4], m_cnt[4], m_pend[4], m_pz[4];
  int m_up, m_lo, m_deb, m_apply, m_ok, m_err, m_ev, m_ch, m_ez, m_last, m_ovr;

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_zone[c] = 0; m_cand[c] = 0; m_cnt[c] = 0; m_pend[c] = 0; m_pz[c] = 0;
    end
    m_up = 105; m_lo = 95; m_deb = 3; m_apply = 0; m_ok = 0; m_err = 0;
    m_ev = 0; m_ch = 0; m_ez = 0; m_last = 3; m_ovr = 0;
  endtask

  task automatic model_step(input logic [3:0] pv, input logic [31:0] pr, input logic er,
                            input logic cv, input logic [7:0] cu, input logic [7:0] cl,
                            input logic [3:0] cd);
    int cm[4];
    int cz[4];
    int pend_old[4];
    int g, p, cls, need, accept;
    for (int c = 0; c < 4; c++) begin
      cm[c] = 0; cz[c] = 0; pend_old[c] = m_pend[c];
    end
    if (m_apply == 0) begin
      for (int c = 0; c < 4; c++) begin
        if (pv[c]) begin
          p   = int'(pr[c*8 +: 8]);
          cls = (p > m_up) ? 3 : (p < m_lo) ? 2 : 1;
          if (cls == m_zone[c]) m_cnt[c] = 0;
          else begin
            if (cls == m_cand[c]) m_cnt[c] = (m_cnt[c] < 15) ? m_cnt[c] + 1 : 15;
            else begin m_cand[c] = cls; m_cnt[c] = 1; end
            need = (m_deb == 0) ? 1 : m_deb;
            if (m_cnt[c] >= need) begin
              m_zone[c] = m_cand[c]; m_cnt[c] = 0; cm[c] = 1; cz[c] = m_zone[c];
            end
          end
        end
      end
    end
    if (m_ok != 0) for (int c = 0; c < 4; c++) begin m_cand[c] = 0; m_cnt[c] = 0; end
    g = -1;
    if (m_ev == 0 || er) begin
      for (int i = 1; i <= 4; i++) begin
        int k;
        k = (m_last + i) % 4;
        if (g < 0 && m_pend[k] != 0) g = k;
      end
      if (g >= 0) begin
        m_ev = 1; m_ch = g; m_ez = m_pz[g]; m_pend[g] = 0; m_last = g;
      end else m_ev = 0;
    end
    m_ovr = 0;
    for (int c = 0; c < 4; c++) begin
      if (cm[c] != 0) begin
        if (pend_old[c] != 0 && g != c) m_ovr = 1;
        m_pend[c] = 1; m_pz[c] = cz[c];
      end
    end
    accept  = (cv && m_apply == 0) ? 1 : 0;
    m_apply = accept;
    m_ok    = (accept != 0 && cu >= cl) ? 1 : 0;
    m_err   = (accept != 0 && cu < cl) ? 1 : 0;
    if (m_ok != 0) begin m_up = int'(cu); m_lo = int'(cl); m_deb = int'(cd); end
  endtask

  task automatic model_check();
    int ez;
    ez = 0;
    for (int c = 0; c < 4; c++) ez += m_zone[c] << (2*c);
    chk("model zone", zone, ez);
    chk("model evt_valid", evt_valid, m_ev);
    if (m_ev != 0) begin
      chk("model evt_ch", evt_ch, m_ch);
      chk("model evt_zone", evt_zone, m_ez);
    end
    chk("model evt_overrun", evt_overrun, m_ovr);
    chk("model cfg_ready", cfg_ready, (m_apply == 0) ? 1 : 0);
    chk("model cfg_err", cfg_err, m_err);
  endtask

  task automatic cyc(input logic [3:0] pv, input logic [31:0] pr, input logic er,
                     input logic cv, input logic [7:0] cu, input logic [7:0] cl,
                     input logic [3:0] cd);
    price_valid = pv; price = pr; evt_ready = er;
    cfg_valid = cv; cfg_upper = cu; cfg_lower = cl; cfg_debounce = cd;
    model_step(pv, pr, er, cv, cu, cl, cd);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic er);
    cyc(4'h0, 32'h0, er, 1'b0, 8'd0, 8'd0, 4'd0);
  endtask

  task automatic async_reset();
    #3 reset_n = 1'b0;
    #1;
    model_reset();
    price_valid = '0; cfg_valid = 1'b0; evt_ready = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  pv;
    logic [31:0] pr;
    logic        er, cv;
    logic [7:0]  cu, cl;
    logic [3:0]  cd;
    logic [7:0]  ezone;
    logic        ev;
    logic [1:0]  ech, ez;
    logic        eerr, eovr, erdy;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input logic [3:0] pv, input logic [31:0] pr, input logic er,
                     input logic cv, input logic [7:0] cu, input logic [7:0] cl,
                     input logic [3:0] cd, input logic [7:0] ezone, input logic ev,
                     input logic [1:0] ech, input logic [1:0] ez, input logic eerr,
                     input logic eovr, input logic erdy);
    vec_t v;
    v.pv = pv; v.pr = pr; v.er = er; v.cv = cv; v.cu = cu; v.cl = cl; v.cd = cd;
    v.ezone = ezone; v.ev = ev; v.ech = ech; v.ez = ez;
    v.eerr = eerr; v.eovr = eovr; v.erdy = erdy;
    tbl.push_back(v);
  endtask

  initial begin
    reset_n = 1'b0; price_valid = '0; price = '0; evt_ready = 1'b1;
    cfg_valid = 1'b0; cfg_upper = '0; cfg_lower = '0; cfg_debounce = '0;
    model_reset();
    #12;
    chk("reset zone", zone, 0);
    chk("reset evt_valid", evt_valid, 0);
    chk("reset evt_ch", evt_ch, 0);
    chk("reset evt_zone", evt_zone, 0);
    chk("reset cfg_ready", cfg_ready, 1);
    chk("reset cfg_err", cfg_err, 0);
    chk("reset evt_overrun", evt_overrun, 0);
    @(negedge clk) reset_n = 1'b1;

    // ch0 HIGH after three samples at debounce 3
    row(4'h1, 32'h0000006E, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 1);
    row(4'h1, 32'h0000006E, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 1);
    row(4'h1, 32'h0000006E, 1, 0, 0, 0, 0, 8'h03, 0, 0, 0, 0, 0, 1);
    row(4'h0, 32'h0,        1, 0, 0, 0, 0, 8'h03, 1, 0, 3, 0, 0, 1);
    row(4'h0, 32'h0,        1, 0, 0, 0, 0, 8'h03, 0, 0, 0, 0, 0, 1);
    // ch1: candidate restarts on the interleaved band sample
    row(4'h2, 32'h00006E00, 1, 0, 0, 0, 0, 8'h03, 0, 0, 0, 0, 0, 1);
    row(4'h2, 32'h00006400, 1, 0, 0, 0, 0, 8'h03, 0, 0, 0, 0, 0, 1);
    row(4'h2, 32'h00006E00, 1, 0, 0, 0, 0, 8'h03, 0, 0, 0, 0, 0, 1);
    row(4'h2, 32'h00006E00, 1, 0, 0, 0, 0, 8'h03, 0, 0, 0, 0, 0, 1);
    row(4'h2, 32'h00006E00, 1, 0, 0, 0, 0, 8'h0F, 0, 0, 0, 0, 0, 1);
    row(4'h0, 32'h0,        1, 0, 0, 0, 0, 8'h0F, 1, 1, 3, 0, 0, 1);
    row(4'h0, 32'h0,        1, 0, 0, 0, 0, 8'h0F, 0, 0, 0, 0, 0, 1);
    // rejected config, then defaults still classify 100 as band
    row(4'h0, 32'h0,        1, 1, 50, 60, 2, 8'h0F, 0, 0, 0, 1, 0, 0);
    row(4'h0, 32'h0,        1, 0, 0, 0, 0, 8'h0F, 0, 0, 0, 0, 0, 1);
    row(4'h4, 32'h00640000, 1, 0, 0, 0, 0, 8'h0F, 0, 0, 0, 0, 0, 1);
    row(4'h4, 32'h00640000, 1, 0, 0, 0, 0, 8'h0F, 0, 0, 0, 0, 0, 1);
    row(4'h4, 32'h00640000, 1, 0, 0, 0, 0, 8'h1F, 0, 0, 0, 0, 0, 1);
    row(4'h0, 32'h0,        1, 0, 0, 0, 0, 8'h1F, 1, 2, 1, 0, 0, 1);
    row(4'h0, 32'h0,        1, 0, 0, 0, 0, 8'h1F, 0, 0, 0, 0, 0, 1);
    // accepted config 120/80, debounce 0 commits on first sample
    row(4'h0, 32'h0,        1, 1, 120, 80, 0, 8'h1F, 0, 0, 0, 0, 0, 0);
    row(4'h0, 32'h0,        1, 0, 0, 0, 0, 8'h1F, 0, 0, 0, 0, 0, 1);
    row(4'h8, 32'h64000000, 1, 0, 0, 0, 0, 8'h5F, 0, 0, 0, 0, 0, 1);
    row(4'h0, 32'h0,        1, 0, 0, 0, 0, 8'h5F, 1, 3, 1, 0, 0, 1);
    row(4'h0, 32'h0,        1, 0, 0, 0, 0, 8'h5F, 0, 0, 0, 0, 0, 1);
    // all channels commit LOW together; stall, then drain in order
    row(4'hF, 32'h46464646, 0, 0, 0, 0, 0, 8'hAA, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++)
      row(4'h0, 32'h0,      0, 0, 0, 0, 0, 8'hAA, 1, 0, 2, 0, 0, 1);
    row(4'h0, 32'h0,        1, 0, 0, 0, 0, 8'hAA, 1, 1, 2, 0, 0, 1);
    row(4'h0, 32'h0,        1, 0, 0, 0, 0, 8'hAA, 1, 2, 2, 0, 0, 1);
    row(4'h0, 32'h0,        1, 0, 0, 0, 0, 8'hAA, 1, 3, 2, 0, 0, 1);
    row(4'h0, 32'h0,        1, 0, 0, 0, 0, 8'hAA, 0, 0, 0, 0, 0, 1);
    // ch2: band, then low in the grant cycle, then high while stalled -> overrun
    row(4'h4, 32'h00640000, 0, 0, 0, 0, 0, 8'h9A, 0, 0, 0, 0, 0, 1);
    row(4'h4, 32'h00460000, 0, 0, 0, 0, 0, 8'hAA, 1, 2, 1, 0, 0, 1);
    row(4'h4, 32'h00820000, 0, 0, 0, 0, 0, 8'hBA, 1, 2, 1, 0, 1, 1);
    row(4'h0, 32'h0,        0, 0, 0, 0, 0, 8'hBA, 1, 2, 1, 0, 0, 1);
    row(4'h0, 32'h0,        1, 0, 0, 0, 0, 8'hBA, 1, 2, 3, 0, 0, 1);
    row(4'h0, 32'h0,        1, 0, 0, 0, 0, 8'hBA, 0, 0, 0, 0, 0, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].pv, tbl[i].pr, tbl[i].er, tbl[i].cv, tbl[i].cu, tbl[i].cl, tbl[i].cd);
      chk($sformatf("row%0d zone", i), zone, tbl[i].ezone);
      chk($sformatf("row%0d evt_valid", i), evt_valid, tbl[i].ev);
      if (tbl[i].ev) begin
        chk($sformatf("row%0d evt_ch", i), evt_ch, tbl[i].ech);
        chk($sformatf("row%0d evt_zone", i), evt_zone, tbl[i].ez);
      end
      chk($sformatf("row%0d cfg_err", i), cfg_err, tbl[i].eerr);
      chk($sformatf("row%0d evt_overrun", i), evt_overrun, tbl[i].eovr);
      chk($sformatf("row%0d cfg_ready", i), cfg_ready, tbl[i].erdy);
    end

    // reset while an event is held and a config is in flight
    cyc(4'h1, 32'h00000082, 0, 0, 0, 0, 0);
    chk("pre-reset zone", zone, 8'hBB);
    idle(1'b0);
    chk("pre-reset evt_valid", evt_valid, 1);
    cyc(4'h0, 32'h0, 0, 1, 110, 90, 2);
    async_reset();
    chk("async zone", zone, 0);
    chk("async evt_valid", evt_valid, 0);
    chk("async evt_ch", evt_ch, 0);
    chk("async evt_zone", evt_zone, 0);
    chk("async cfg_ready", cfg_ready, 1);
    @(negedge clk) reset_n = 1'b1;

    // reset mid-debounce restarts the count; discarded config leaves debounce at 3
    cyc(4'h2, 32'h00006E00, 1, 0, 0, 0, 0);
    chk("no stale evt", evt_valid, 0);
    cyc(4'h2, 32'h00006E00, 1, 0, 0, 0, 0);
    chk("deb3 two samples", zone, 0);
    async_reset();
    chk("async2 zone", zone, 0);
    @(negedge clk) reset_n = 1'b1;
    cyc(4'h2, 32'h00006E00, 1, 0, 0, 0, 0);
    chk("restart s1", zone, 0);
    cyc(4'h2, 32'h00006E00, 1, 0, 0, 0, 0);
    chk("restart s2", zone, 0);
    cyc(4'h2, 32'h00006E00, 1, 0, 0, 0, 0);
    chk("restart s3", zone, 8'h0C);
    idle(1'b1);
    chk("restart evt_valid", evt_valid, 1);
    chk("restart evt_ch", evt_ch, 1);
    chk("restart evt_zone", evt_zone, 3);

    // randomized run against the model
    async_reset();
    @(negedge clk) reset_n = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] pr;
      for (int c = 0; c < 4; c++) pr[c*8 +: 8] = 8'($urandom_range(75, 135));
      cyc(4'($urandom), pr, ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
          8'($urandom_range(80, 130)), 8'($urandom_range(80, 130)), 4'($urandom_range(0, 4)));
      model_check();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/price_band_monitor.md
# price_band_monitor

Multi-channel, runtime-programmable successor to the single-channel price threshold detector. Classifies NUM_CH independent price streams into LOW / BAND / HIGH zones, applying a shared debounce to every zone change and holding the committed zone per channel. Thresholds and debounce length are loaded through a validated config handshake. Zone changes are reported on a round-robin arbitrated valid/ready event port. Sits between the market-data ingest stage and downstream alerting logic.

## Interface
- NUM_CH, 4: number of independent price channels (>=1)
- PRICE_W, 8: price width, unsigned
- CNT_W, 4: debounce counter / debounce register width
- DEFAULT_UPPER, 105: upper threshold after reset
- DEFAULT_LOWER, 95: lower threshold after reset (elaboration check: DEFAULT_UPPER >= DEFAULT_LOWER)
- DEFAULT_DEBOUNCE, 3: debounce sample count after reset
- clk  in  1  single clock, all logic on posedge
- reset_n  in  1  asynchronous, active-low reset
- price_valid  in  NUM_CH  per-channel sample strobe
- price  in  NUM_CH*PRICE_W  channel c at bits [c*PRICE_W +: PRICE_W]
- cfg_valid  in  1  config request
- cfg_ready  out  1  config accept; transfer when cfg_valid && cfg_ready
- cfg_upper, cfg_lower  in  PRICE_W each  new thresholds
- cfg_debounce  in  CNT_W  new debounce count
- cfg_err  out  1  one-cycle pulse: accepted config rejected
- zone  out  NUM_CH*2  committed zone per channel: 00 IDLE, 01 BAND, 10 LOW, 11 HIGH
- evt_valid  out  1  event pending on output register
- evt_ready  in  1  consumer accept
- evt_ch  out  $clog2(NUM_CH) (min 1)  channel of event
- evt_zone  out  2  new zone of event
- evt_overrun  out  1  one-cycle pulse: an unsent pending event was overwritten

## Operation
- Classification (strict hysteresis): price > upper -> HIGH; price < lower -> LOW; else BAND. Uses thresholds registered at start of cycle.
- Per-channel state: committed zone, candidate zone, counter. Only cycles with price_valid count; invalid cycles hold all state.
- Sample class == committed zone: counter cleared.
- Sample class != committed: if class == candidate, counter+1, else candidate <= class and counter <= 1. Commit when counter reaches max(debounce,1): zone <= candidate, counter cleared. Debounce 0 behaves as 1.
- IDLE is left only through a debounced commit, like any other change.
- Counter saturates at 2^CNT_W-1.
- Config: cfg_ready high except the single apply cycle after acceptance. If cfg_upper < cfg_lower: registers unchanged, cfg_err pulses next cycle, counters untouched. Otherwise thresholds/debounce update next cycle and all channels' candidates and counters clear; committed zones kept. Samples in the apply cycle are ignored for debounce.
- Events: every commit sets the channel's pending bit and pending zone. If pending already set, pending zone is overwritten with the newer one and evt_overrun pulses.
- Arbiter: when output register is empty or emptying (evt_valid && evt_ready), grant the next pending channel round-robin after the last granted one; load evt_ch/evt_zone, clear that pending bit.
- Same-cycle grant and new commit on one channel: grant carries the old zone; pending stays set with the new zone; no overrun.
- evt_ch/evt_zone stable while evt_valid && !evt_ready.

## Timing
- Reset (async assert, sync release): zone all 00, thresholds/debounce = defaults, counters/candidates/pending clear, evt_valid 0, evt_ch/evt_zone 0, cfg_ready 1, cfg_err 0, evt_overrun 0.
- Commit-causing sample at cycle t: zone updates at t+1; pending set at t+1; evt_valid earliest at t+2.
- Back-to-back events: one per cycle with evt_ready held high.
- Config accepted at t: new values effective from t+1 samples; cfg_ready low at t+1, high at t+2; cfg_err (if rejected) at t+1.
- Reset mid-operation discards pending events and in-flight config.

## Structure
- Package price_mon_pkg: zone_t enum (ZONE_IDLE, ZONE_BAND, ZONE_LOW, ZONE_HIGH), classify function (price, upper, lower -> zone_t).
- Sub-module price_band_channel: one channel's classify/debounce/commit FSM, emits commit pulse + zone. Instantiated NUM_CH times by generate.
- Config registers, pending bits, round-robin arbiter and event register live in the top.

## Test plan
- Reset, ch0 price 110 valid 3 cycles (debounce 3) -> zone[0]=11 one cycle after third sample; event ch0/zone 11 one cycle later.
- ch1 alternates 110, 100, 110, 110 -> no commit until counter restarts; HIGH commits only after 3 consecutive 110s.
- Config upper 50, lower 60 -> cfg_err pulse, thresholds stay 105/95. Config 120/80/debounce 0 -> price 100 commits BAND on the first sample.
- All 4 channels commit same cycle, evt_ready held low 5 cycles then high -> events drain ch0..ch3 in order, one per cycle, output stable while stalled.
- ch2 commits LOW then HIGH while evt_ready low -> evt_overrun pulse; delivered ch2 event zone 11.
- reset_n asserted mid-debounce and with evt_valid high -> outputs return to reset values immediately; no stale event after release.
